// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: address/data widths,
// MDU result buffer entry layout and the grant-source encoding.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic                  killed;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_PIPE,
        GNT_FIFO,
        GNT_FORCE
    } gnt_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB-stage, MDU, issue-stage and register-file write signals seen by
// the write-port arbiter. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  pipe_we_i;
    logic [REG_ADDR_W-1:0] pipe_rd_i;
    logic [XLEN-1:0]       pipe_data_i;
    logic                  pipe_stall_o;
    logic                  mdu_valid_i;
    logic [REG_ADDR_W-1:0] mdu_rd_i;
    logic [XLEN-1:0]       mdu_data_i;
    logic                  mdu_ready_o;
    logic [REG_ADDR_W-1:0] rs1_label_i;
    logic [REG_ADDR_W-1:0] rs2_label_i;
    logic                  hazard_o;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_rd_o;
    logic [XLEN-1:0]       rf_data_o;

    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_data_i,
        input  mdu_valid_i, mdu_rd_i, mdu_data_i,
        input  rs1_label_i, rs2_label_i,
        output pipe_stall_o, mdu_ready_o, hazard_o,
        output rf_we_o, rf_rd_o, rf_data_o
    );

    modport master (
        output pipe_we_i, pipe_rd_i, pipe_data_i,
        output mdu_valid_i, mdu_rd_i, mdu_data_i,
        output rs1_label_i, rs2_label_i,
        input  pipe_stall_o, mdu_ready_o, hazard_o,
        input  rf_we_o, rf_rd_o, rf_data_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_result_fifo.sv
// MDU result buffer: in-order FIFO with per-entry kill-by-rd (WAW squash)
// and a source-register match output used for RAW hazard detection.
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [XLEN-1:0]       push_data_i,
    input  logic                  pop_i,
    input  logic                  kill_i,
    input  logic [REG_ADDR_W-1:0] kill_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_label_i,
    input  logic [REG_ADDR_W-1:0] rs2_label_i,
    output fifo_entry_t           head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  match_o
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t     mem_q [DEPTH];
    fifo_entry_t     mem_d [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // A newer pipeline write to the same rd makes buffered values obsolete.
        if (kill_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].rd == kill_rd_i)) begin
                    mem_d[i].killed = 1'b1;
                end
            end
        end
        if (pop_i && !empty_o) begin
            mem_d[rd_ptr_q[AW-1:0]].valid  = 1'b0;
            mem_d[rd_ptr_q[AW-1:0]].killed = 1'b0;
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push_i && !full_o) begin
            mem_d[wr_ptr_q[AW-1:0]].valid  = 1'b1;
            mem_d[wr_ptr_q[AW-1:0]].killed = 1'b0;
            mem_d[wr_ptr_q[AW-1:0]].rd     = push_rd_i;
            mem_d[wr_ptr_q[AW-1:0]].data   = push_data_i;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
    end

    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].valid && !mem_q[i].killed && (mem_q[i].rd != '0) &&
                ((mem_q[i].rd == rs1_label_i) || (mem_q[i].rd == rs2_label_i))) begin
                match_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid  <= 1'b0;
                mem_q[i].killed <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and the buffered MDU.
// Optional same-cycle MDU bypass when idle: define REGFILE_ARB_MDU_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int             SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

    fifo_entry_t           head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_match;
    logic                  pipe_req;
    logic                  head_live;
    logic                  head_killed;
    logic                  mdu_ready;
    logic                  byp;
    logic                  push;
    logic                  pop;
    logic                  kill;
    gnt_src_e              gnt;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_data;
    logic [SW-1:0]         starve_q, starve_d;

    assign pipe_req    = bus.pipe_we_i && (bus.pipe_rd_i != '0) && !rst_i;
    assign head_live   = !fifo_empty && head.valid && !head.killed;
    assign head_killed = !fifo_empty && head.killed;
    assign mdu_ready   = !fifo_full && !rst_i;

`ifdef REGFILE_ARB_MDU_BYPASS_EN
    assign byp = fifo_empty && !pipe_req && bus.mdu_valid_i &&
                 (bus.mdu_rd_i != '0) && !rst_i;
`else
    assign byp = 1'b0;
`endif

    // rd == 0 results are acknowledged but never stored.
    assign push = bus.mdu_valid_i && mdu_ready && (bus.mdu_rd_i != '0) && !byp;
    assign pop  = head_killed || (gnt == GNT_FIFO) || (gnt == GNT_FORCE);
    assign kill = (gnt == GNT_PIPE);

    always_comb begin
        gnt = GNT_IDLE;
        if (head_live && (starve_q == STARVE_MAX)) begin
            gnt = GNT_FORCE;
        end else if (pipe_req) begin
            gnt = GNT_PIPE;
        end else if (head_live) begin
            gnt = GNT_FIFO;
        end
    end

    always_comb begin
        rf_we   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        unique case (gnt)
            GNT_PIPE: begin
                rf_we   = 1'b1;
                rf_rd   = bus.pipe_rd_i;
                rf_data = bus.pipe_data_i;
            end
            GNT_FIFO, GNT_FORCE: begin
                rf_we   = 1'b1;
                rf_rd   = head.rd;
                rf_data = head.data;
            end
            default: begin
                if (byp) begin
                    rf_we   = 1'b1;
                    rf_rd   = bus.mdu_rd_i;
                    rf_data = bus.mdu_data_i;
                end
            end
        endcase
    end

    // Counts cycles the live head has lost arbitration; any pop restarts it.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (head_live && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_rd_i   (bus.mdu_rd_i),
        .push_data_i (bus.mdu_data_i),
        .pop_i       (pop),
        .kill_i      (kill),
        .kill_rd_i   (bus.pipe_rd_i),
        .rs1_label_i (bus.rs1_label_i),
        .rs2_label_i (bus.rs2_label_i),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .match_o     (fifo_match)
    );

    assign bus.pipe_stall_o = (gnt == GNT_FORCE);
    assign bus.mdu_ready_o  = mdu_ready;
    assign bus.hazard_o     = fifo_match;
    assign bus.rf_we_o      = rf_we;
    assign bus.rf_rd_o      = rf_rd;
    assign bus.rf_data_o    = rf_data;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and result buffer for the 32x32 register file. It shares the file's single write port between the in-order pipeline writeback stage and the multi-cycle unit (MDU: multiply/divide). MDU results are buffered in a small FIFO until a free write slot exists. The block also guarantees MDU forward progress and exposes a read-after-write hazard signal to the issue stage. It sits between the WB stage/MDU and the register file write inputs.

## Interface
- FIFO_DEPTH, 2: MDU result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a valid FIFO head may lose arbitration before the pipeline is stalled; ≥1.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pipe_we_i  in  1  pipeline writeback request.
- pipe_rd_i  in  5  pipeline destination register.
- pipe_data_i  in  32  pipeline writeback data.
- pipe_stall_o  out  1  pipeline writeback refused this cycle; WB must hold its request.
- mdu_valid_i  in  1  MDU result valid.
- mdu_rd_i  in  5  MDU destination register.
- mdu_data_i  in  32  MDU result.
- mdu_ready_o  out  1  MDU result accepted when high together with valid.
- rs1_label_i, rs2_label_i  in  5  source registers of the instruction in issue.
- hazard_o  out  1  a source register has a pending MDU write.
- rf_we_o  out  1  register file write enable.
- rf_rd_o  out  5  register file destination.
- rf_data_o  out  32  register file write data.

## Operation
- FIFO entry: {valid, killed, rd[4:0], data[31:0]}. Read/write pointers are one bit wider than log2(FIFO_DEPTH) to separate full from empty.
- mdu_ready_o = !full, computed from state at the start of the cycle. A push happens on mdu_valid_i && mdu_ready_o. A result with mdu_rd_i == 0 is accepted and discarded, with no push.
- Pipeline requests with pipe_rd_i == 0 count as no request.
- Killed head entry: popped without using the port, in any cycle. The grant logic sees the next cycle's head.
- Arbitration for the live (not killed) head, in priority order:
  - FORCE: starve counter == STARVE_LIMIT and head live. The FIFO head is granted and pipe_stall_o = 1.
  - PIPE: pipe request present. The pipe is granted.
  - FIFO: head live. The head is granted and popped.
  - IDLE: rf_we_o = 0.
- Starve counter:
  - Increments when the head is live and not granted. It saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
- WAW squash: a granted pipe write sets killed on every FIFO entry whose rd equals pipe_rd_i. The younger pipe value must survive.
- hazard_o = 1 when any valid, non-killed entry has rd ≠ 0 matching rs1_label_i or rs2_label_i. Pure combinational.
- rf_* outputs are combinational from the grant. The register file captures them on the next rising edge.

## Timing
- During and after reset: FIFO empty, counter 0, rf_we_o = 0, pipe_stall_o = 0, hazard_o = 0. mdu_ready_o = 0 while rst_i is high and 1 after.
- Reset mid-operation discards all buffered results.
- Pipe write latency: 0 cycles (same cycle on rf_*) unless stalled.
- MDU latency without bypass: at least 1 cycle (push at edge N, earliest write cycle N+1).
- Full FIFO with a simultaneous pop: ready stays low that cycle. No push-on-full.
- Push and pop to an empty FIFO in the same cycle: no pop, because empty is sampled at cycle start.
- Worst-case MDU head wait: STARVE_LIMIT+1 cycles.

## Configuration
- REGFILE_ARB_MDU_BYPASS_EN defined: when the FIFO is empty, there is no pipe request, and mdu_valid_i is high with mdu_rd_i ≠ 0, the MDU result drives rf_* directly in the same cycle with no push (0-cycle latency).
- Undefined: every MDU result goes through the FIFO.

## Structure
- Shared core package holds:
  - REG_ADDR_W = 5 and XLEN = 32.
  - the FIFO entry struct type.
  - the grant-source enum {GNT_IDLE, GNT_PIPE, GNT_FIFO, GNT_FORCE}.
- One sub-module: wb_result_fifo. It implements storage, pointers, the per-entry kill-by-rd input, and rd-match outputs for hazard detection.
- Arbitration, the starve counter and the bypass logic stay in the top level.

## Test plan
- Reset, then MDU writes x5=0x1234 with no pipe traffic -> ready=1; rf_we_o=1 with rd=5, data=0x1234 one cycle later (same cycle with bypass).
- Pipe writes every cycle while the MDU pushes x7=0xAA -> pipe granted 4 cycles, then pipe_stall_o=1 for one cycle with rf_rd_o=7; pipe write is held and issues the next cycle.
- MDU pushes 2 results under continuous pipe traffic -> mdu_ready_o drops to 0 while full; third result waits; no entry is lost or reordered.
- MDU x9=1 buffered, then pipe writes x9=2 -> entry killed; x9 is never written with 1; hazard_o clears for rs1=9.
- Buffered x3 with rs1_label_i=3 -> hazard_o=1; rs2=0 with an entry rd=0 -> hazard_o=0.
- Assert rst_i with 2 entries buffered -> rf_we_o=0 immediately; after release FIFO empty, no stale writes.
